// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI slave that writes one addressed frame at a time into a bank
// of double-buffered registers. Each register has a pending buffer that goes
// live on a load strobe, or the frame can bypass the buffer with its IMM flag.
module spi_reg_bank #(
   parameter int                          NUM_REGS = 6,
   parameter int                          ADDR_W   = 3,
   parameter int                          DATA_W   = 16,
   parameter logic [NUM_REGS*DATA_W-1:0]  INIT     = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i_sclk,
   input  logic                           i_ss_n,
   input  logic                           i_mosi,
   input  logic                           load_if_ready,
   input  logic                           i_cancel,
   output logic [NUM_REGS*DATA_W-1:0]     o_regs,
   output logic [NUM_REGS-1:0]            o_pending,
   output logic                           o_overrun,
   output logic                           o_bad_addr
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

   // Synchroniser stages; index 0 is the newest sample.
   logic [2:0]                 sclk_sync_q;
   logic [1:0]                 ss_sync_q;
   logic [1:0]                 mosi_sync_q;
   logic                       sclk_rise_s;
   logic                       ss_active_s;
   logic                       mosi_s;

   // Frame assembly.
   logic [FRAME_W-1:0]         shift_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       commit_q;
   logic                       frame_imm_s;
   logic [ADDR_W-1:0]          frame_addr_s;
   logic [DATA_W-1:0]          frame_data_s;

   // Register bank: live values, pending buffers and pending flags.
   logic [NUM_REGS*DATA_W-1:0] live_q, live_d;
   logic [NUM_REGS*DATA_W-1:0] buf_q,  buf_d;
   logic [NUM_REGS-1:0]        pend_q, pend_d;
   logic                       ovr_q,  ovr_d;
   logic                       bad_q,  bad_d;
   logic                       do_load_s;
   logic                       addr_hit_s;

   // Bring the asynchronous SPI pins into the clk domain; idle is sclk low, ss high.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= 3'b000;
         ss_sync_q   <= 2'b11;
         mosi_sync_q <= 2'b00;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], i_sclk};
         ss_sync_q   <= {ss_sync_q[0], i_ss_n};
         mosi_sync_q <= {mosi_sync_q[0], i_mosi};
      end
   end

   assign sclk_rise_s = (sclk_sync_q[2:1] == 2'b01);
   assign ss_active_s = ~ss_sync_q[1];
   assign mosi_s      = mosi_sync_q[1];

   // Shift frame bits on SCLK rises; wrap the counter so frames may run back to back.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q  <= '0;
         cnt_q    <= '0;
         commit_q <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         if (!ss_active_s) begin
            // Deselect abandons any partial frame.
            cnt_q <= '0;
         end else if (sclk_rise_s) begin
            shift_q <= {shift_q[FRAME_W-2:0], mosi_s};
            if (cnt_q == LAST_BIT) begin
               cnt_q    <= '0;
               commit_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_q <= cnt_q;
         end
      end
   end

   assign frame_imm_s  = shift_q[FRAME_W-1];
   assign frame_addr_s = shift_q[FRAME_W-2 -: ADDR_W];
   assign frame_data_s = shift_q[DATA_W-1:0];

   // Next bank state: load first, then the frame commit, then cancel overrides pending flags.
   always_comb begin
      live_d     = live_q;
      buf_d      = buf_q;
      pend_d     = pend_q;
      ovr_d      = 1'b0;
      bad_d      = 1'b0;
      addr_hit_s = 1'b0;
      do_load_s  = load_if_ready & ~i_cancel;

      for (int i = 0; i < NUM_REGS; i++) begin
         if (do_load_s && pend_q[i]) begin
            live_d[i*DATA_W +: DATA_W] = buf_q[i*DATA_W +: DATA_W];
            pend_d[i]                  = 1'b0;
         end else begin
            pend_d[i] = pend_d[i];
         end
      end

      if (commit_q) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (frame_addr_s == ADDR_W'(i)) begin
               addr_hit_s = 1'b1;
               if (frame_imm_s) begin
                  // Immediate write beats any same-edge load of this register.
                  live_d[i*DATA_W +: DATA_W] = frame_data_s;
               end else begin
                  // A same-edge load already moved the old buffer live, so nothing is lost.
                  ovr_d                     = pend_q[i] & ~do_load_s;
                  buf_d[i*DATA_W +: DATA_W] = frame_data_s;
                  pend_d[i]                 = 1'b1;
               end
            end else begin
               addr_hit_s = addr_hit_s;
            end
         end
         bad_d = ~addr_hit_s;
      end else begin
         bad_d = 1'b0;
      end

      if (i_cancel) begin
         pend_d = '0;
      end else begin
         pend_d = pend_d;
      end
   end

   // Bank state and status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         live_q <= INIT;
         buf_q  <= '0;
         pend_q <= '0;
         ovr_q  <= 1'b0;
         bad_q  <= 1'b0;
      end else begin
         live_q <= live_d;
         buf_q  <= buf_d;
         pend_q <= pend_d;
         ovr_q  <= ovr_d;
         bad_q  <= bad_d;
      end
   end

   assign o_regs     = live_q;
   assign o_pending  = pend_q;
   assign o_overrun  = ovr_q;
   assign o_bad_addr = bad_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: frame-level model plus hand-computed checkpoints.
module tb_spi_reg_bank;

   localparam int NR = 6;
   localparam int DW = 16;

   function automatic logic [NR*DW-1:0] make_init();
      logic [NR*DW-1:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = 16'h1000 + 16'(i);
      return v;
   endfunction

   localparam logic [NR*DW-1:0] INIT_V = make_init();

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              i_sclk = 1'b0;
   logic              i_ss_n = 1'b1;
   logic              i_mosi = 1'b0;
   logic              load_if_ready = 1'b0;
   logic              i_cancel = 1'b0;
   logic [NR*DW-1:0]  o_regs;
   logic [NR-1:0]     o_pending;
   logic              o_overrun;
   logic              o_bad_addr;

   spi_reg_bank #(.NUM_REGS(NR), .ADDR_W(3), .DATA_W(DW), .INIT(INIT_V)) dut (
      .clk(clk), .reset(reset), .i_sclk(i_sclk), .i_ss_n(i_ss_n), .i_mosi(i_mosi),
      .load_if_ready(load_if_ready), .i_cancel(i_cancel), .o_regs(o_regs),
      .o_pending(o_pending), .o_overrun(o_overrun), .o_bad_addr(o_bad_addr)
   );

   always #5 clk = ~clk;

   // Model: commits are scheduled by the frame sender at a fixed edge count.
   typedef struct { logic [19:0] frame; int at; } cmt_t;
   cmt_t           cq[$];
   int             cyc = 0;
   logic [DW-1:0]  m_live[NR];
   logic [DW-1:0]  m_buf[NR];
   logic [NR-1:0]  m_pend;
   logic           m_ovr, m_bad;
   logic           m_do_load;
   logic [NR-1:0]  m_old_pend;
   cmt_t           m_c;
   int             m_a;

   // Frame-level behavioural model, updated on every clk edge.
   always @(posedge clk) begin
      cyc = cyc + 1;
      m_ovr = 1'b0;
      m_bad = 1'b0;
      if (reset) begin
         for (int i = 0; i < NR; i++) begin
            m_live[i] = INIT_V[i*DW +: DW];
            m_buf[i]  = 16'h0000;
         end
         m_pend = '0;
         cq.delete();
      end else begin
         m_do_load  = load_if_ready && !i_cancel;
         m_old_pend = m_pend;
         if (m_do_load)
            for (int i = 0; i < NR; i++)
               if (m_old_pend[i]) begin
                  m_live[i] = m_buf[i];
                  m_pend[i] = 1'b0;
               end
         if (cq.size() > 0 && cq[0].at == cyc) begin
            m_c = cq.pop_front();
            m_a = int'(m_c.frame[18:16]);
            if (m_a >= NR) m_bad = 1'b1;
            else if (m_c.frame[19]) m_live[m_a] = m_c.frame[15:0];
            else begin
               if (m_old_pend[m_a] && !m_do_load) m_ovr = 1'b1;
               m_buf[m_a]  = m_c.frame[15:0];
               m_pend[m_a] = 1'b1;
            end
         end
         if (i_cancel) m_pend = '0;
      end
   end

   // Counters and literal-check handshake (written only by the compare process).
   int            n_total = 0;
   int            n_bad = 0;
   int            ovr_cnt = 0;
   int            bad_cnt = 0;
   int            lit_done = 0;
   int            lit_seq = 0;
   string         lit_name;
   logic [31:0]   lit_act, lit_exp;
   logic          chk_en = 1'b0;

   task automatic do_cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         if (n_bad <= 40) $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", nm, idx, cyc, act, exp);
      end
   endtask

   // Compare process: DUT against the model every cycle, plus requested literal checks.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NR; i++) do_cmp("reg", i, 32'(o_regs[i*DW +: DW]), 32'(m_live[i]));
         do_cmp("pending", 0, 32'(o_pending), 32'(m_pend));
         do_cmp("overrun", 0, 32'(o_overrun), 32'(m_ovr));
         do_cmp("bad_addr", 0, 32'(o_bad_addr), 32'(m_bad));
         if (o_overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
         if (o_bad_addr === 1'b1) bad_cnt = bad_cnt + 1;
      end
      if (lit_seq != lit_done) begin
         lit_done = lit_seq;
         do_cmp(lit_name, -1, lit_act, lit_exp);
      end
   end

   task automatic check_lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      lit_name = nm;
      lit_act  = act;
      lit_exp  = exp;
      lit_seq  = lit_seq + 1;
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] reg_of(input int i);
      return 32'(o_regs[i*DW +: DW]);
   endfunction

   task automatic ss_low();
      @(negedge clk); i_ss_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic ss_high();
      @(negedge clk); i_ss_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Sends nbits of a frame MSB first; a full frame schedules its commit in the model.
   task automatic send_frame(input logic imm, input logic [2:0] addr, input logic [15:0] data,
                             input int nbits, input logic ld, input logic cn);
      logic [19:0] f;
      f = {imm, addr, data};
      for (int b = 0; b < nbits; b++) begin
         @(negedge clk); i_mosi = f[19-b]; i_sclk = 1'b0;
         repeat (4) @(negedge clk);
         i_sclk = 1'b1;
         if (b == 19) begin
            // Rise is seen three edges later (shift edge); commit lands one edge after that.
            cq.push_back('{f, cyc + 4});
            repeat (3) @(negedge clk);
            load_if_ready = ld;
            i_cancel = cn;
            @(negedge clk);
            load_if_ready = 1'b0;
            i_cancel = 1'b0;
         end else begin
            repeat (4) @(negedge clk);
         end
      end
      @(negedge clk); i_sclk = 1'b0;
   endtask

   task automatic xfer(input logic imm, input logic [2:0] addr, input logic [15:0] data,
                       input logic ld, input logic cn);
      ss_low();
      send_frame(imm, addr, data, 20, ld, cn);
      ss_high();
   endtask

   task automatic pulse_load();
      @(negedge clk); load_if_ready = 1'b1;
      @(negedge clk); load_if_ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   int ovr0, bad0;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check_lit("reset_reg2", reg_of(2), 32'h0000_1002);
      check_lit("reset_pending", 32'(o_pending), 32'h0000_0000);

      // Buffered write then load.
      xfer(1'b0, 3'd3, 16'hBEEF, 1'b0, 1'b0);
      check_lit("buf_pending", 32'(o_pending), 32'h0000_0008);
      check_lit("buf_reg3_old", reg_of(3), 32'h0000_1003);
      pulse_load();
      check_lit("load_reg3", reg_of(3), 32'h0000_BEEF);
      check_lit("load_pending", 32'(o_pending), 32'h0000_0000);

      // Immediate write.
      xfer(1'b1, 3'd1, 16'h1234, 1'b0, 1'b0);
      check_lit("imm_reg1", reg_of(1), 32'h0000_1234);
      check_lit("imm_pending", 32'(o_pending), 32'h0000_0000);
      pulse_load();
      check_lit("imm_reg1_after_load", reg_of(1), 32'h0000_1234);

      // Back-to-back frames to the same register under one select.
      ovr0 = ovr_cnt;
      ss_low();
      send_frame(1'b0, 3'd0, 16'h0001, 20, 1'b0, 1'b0);
      send_frame(1'b0, 3'd0, 16'h0002, 20, 1'b0, 1'b0);
      ss_high();
      check_lit("overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
      check_lit("overrun_reg0_old", reg_of(0), 32'h0000_1000);
      pulse_load();
      check_lit("overrun_reg0", reg_of(0), 32'h0000_0002);

      // Out-of-range address.
      bad0 = bad_cnt;
      xfer(1'b0, 3'd7, 16'hDEAD, 1'b0, 1'b0);
      check_lit("bad_pulses", 32'(bad_cnt - bad0), 32'd1);
      check_lit("bad_pending", 32'(o_pending), 32'h0000_0000);

      // Partial frame abandoned, then a full frame.
      ss_low();
      send_frame(1'b0, 3'd5, 16'h5A5A, 10, 1'b0, 1'b0);
      ss_high();
      xfer(1'b0, 3'd2, 16'hCAFE, 1'b0, 1'b0);
      check_lit("partial_pending", 32'(o_pending), 32'h0000_0004);
      check_lit("partial_reg5", reg_of(5), 32'h0000_1005);
      pulse_load();
      check_lit("partial_reg2", reg_of(2), 32'h0000_CAFE);

      // Commit coinciding with cancel and load.
      xfer(1'b0, 3'd1, 16'hAAAA, 1'b0, 1'b0);
      check_lit("pre_cancel_pending", 32'(o_pending), 32'h0000_0002);
      xfer(1'b0, 3'd4, 16'h5555, 1'b1, 1'b1);
      check_lit("cancel_pending", 32'(o_pending), 32'h0000_0000);
      check_lit("cancel_reg4", reg_of(4), 32'h0000_1004);
      check_lit("cancel_reg1", reg_of(1), 32'h0000_1234);

      // Same again with only load.
      xfer(1'b0, 3'd1, 16'hAAAA, 1'b0, 1'b0);
      xfer(1'b0, 3'd4, 16'h5555, 1'b1, 1'b0);
      check_lit("load_commit_reg1", reg_of(1), 32'h0000_AAAA);
      check_lit("load_commit_pending", 32'(o_pending), 32'h0000_0010);
      check_lit("load_commit_reg4", reg_of(4), 32'h0000_1004);

      // Immediate write on the load edge of a pending register.
      xfer(1'b1, 3'd4, 16'h7777, 1'b1, 1'b0);
      check_lit("imm_load_reg4", reg_of(4), 32'h0000_7777);
      check_lit("imm_load_pending", 32'(o_pending), 32'h0000_0000);
      check_lit("total_overruns", 32'(ovr_cnt), 32'd1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Generalised successor to the single-frame vector loader: an SPI slave feeding a bank of NUM_REGS independent DATA_W-bit registers.
- Each SPI frame addresses one register, so the host can update any subset without resending everything.
- Per-register double buffering: a frame lands in a pending buffer and goes live on the next load_if_ready (frame boundary), or goes live immediately if the frame's IMM flag is set.
- Sits between the external SPI host and the renderer's vector/config inputs.

Parameters:
- NUM_REGS, 6, number of registers in the bank (1..2^ADDR_W).
- ADDR_W, 3, address field width in each frame.
- DATA_W, 16, payload width per register.
- INIT, {NUM_REGS*DATA_W{1'b0}}, flat reset values; reg i occupies bits [i*DATA_W +: DATA_W].
- FRAME_W (derived), 1+ADDR_W+DATA_W, bits per frame (20 at defaults).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_sclk  in  1  SPI clock, asynchronous to clk.
- i_ss_n  in  1  SPI select, active low, asynchronous.
- i_mosi  in  1  SPI data, asynchronous.
- load_if_ready  in  1  single-cycle strobe at the point where pending data may go live.
- i_cancel  in  1  discard all pending (not yet live) data.
- o_regs  out  NUM_REGS*DATA_W  live register values, flat, same packing as INIT.
- o_pending  out  NUM_REGS  per-register "buffered value awaiting load" flags.
- o_overrun  out  1  one-cycle pulse: a commit overwrote a still-pending value.
- o_bad_addr  out  1  one-cycle pulse: frame addressed a register >= NUM_REGS.

Behaviour:
- Reset (sync, active-high, clock clk): o_regs=INIT, o_pending=0, o_overrun=0, o_bad_addr=0, bit counter=0, commit strobe=0. Synchroniser flops also reset: sclk/ss_n history to idle (sclk=0, ss_n=1).
- Synchronisers: SCLK 3-flop chain; rise = stages[2:1]==01. SS_n 2 flops; active = ~stage[1]. MOSI 2 flops.
- Frame format, MSB first: IMM (1b), ADDR (ADDR_W), DATA (DATA_W).
- Shift: while ss active and a rise is detected, shift the MOSI bit into a FRAME_W shift register and advance the counter (width $clog2(FRAME_W)).
- Counter wrap: the counter wraps to 0 after bit FRAME_W-1, so back-to-back frames under one SS assertion are legal.
- SS deassert (synchronised) resets the counter to 0 at any point; a partial frame is discarded and nothing commits.
- Let edge E be the clk edge that shifts in bit FRAME_W-1. The commit strobe is high during the cycle after E, and the commit takes effect at edge E+1.
- Commit at E+1, IMM=0, ADDR<NUM_REGS: buf[ADDR]<=DATA, pending[ADDR]<=1. If pending[ADDR] was already 1, the old buffered value is lost and o_overrun pulses for the cycle after E+1.
- Commit at E+1, IMM=1, ADDR<NUM_REGS: live[ADDR]<=DATA directly. pending[ADDR] and buf[ADDR] are unchanged.
- Commit with ADDR>=NUM_REGS: no state change except an o_bad_addr pulse for the cycle after E+1.
- load_if_ready edge (i_cancel low): for every i with pending[i]=1, live[i]<=buf[i] and pending[i]<=0.
- Same-edge commit (IMM=0) to reg a plus load: live[a] takes the old buf[a] if pending[a] was set; buf[a] takes the new DATA; pending[a] ends at 1. All other registers load normally.
- Same-edge IMM commit to a plus load with pending[a]=1: the IMM value wins for live[a]; pending[a] is cleared.
- i_cancel edge: all pending<=0, including any commit on the same edge. Live values are unchanged; cancel overrides a simultaneous load (no load occurs). IMM commits on the same edge still apply.
- Outputs are registered: o_regs and o_pending reflect state after each edge; there are no combinational paths from inputs to outputs.
- Requirement: SCLK high and low phases must each be >= 3 clk periods. Behaviour for faster SCLK is undefined.

Test Plan:
- Reset with INIT=reg i holding 16'h1000+i -> o_regs[reg 2]=16'h1002; o_pending=0; no pulses.
- SS low; frame IMM=0, ADDR=3, DATA=16'hBEEF; SS high -> o_pending=6'b001000 two clk after the last-bit edge, reg3 unchanged. Then load_if_ready pulse -> reg3=16'hBEEF, o_pending=0.
- Frame IMM=1, ADDR=1, DATA=16'h1234 -> reg1=16'h1234 at E+1, o_pending unchanged; a later load_if_ready leaves reg1 unchanged.
- Two back-to-back IMM=0 frames to ADDR=0 (16'h0001, then 16'h0002) under one SS, no load between -> o_overrun pulses once for one cycle; after load, reg0=16'h0002.
- Frame to ADDR=7 with NUM_REGS=6 -> one o_bad_addr pulse; o_regs and o_pending unchanged. Separately, SS raised after 10 of 20 bits, then a full frame to ADDR=2 -> only the full frame commits.
- Commit (IMM=0, ADDR=4) on the same edge as i_cancel and load_if_ready, with pending[1] previously set -> o_pending=0, reg4 and reg1 unchanged. Repeat with cancel low -> reg1 loads, pending[4]=1.
